// File: rtl/dip_pkg.sv
// dip_pkg: shared types and default sizing for the DIP-switch reader.
// Imported by dip_reader and dip_debounce.
package dip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } dip_state_t;

  localparam int DIP_WIDTH  = 8;
  localparam int DIP_GAP    = 4;
  localparam int DIP_STABLE = 3;

endpackage

// File: rtl/dip_debounce.sv
// dip_debounce: tracks consecutive identical scans and decides when the
// reader may commit a new switch word (used under DIP_DEBOUNCE_EN).
module dip_debounce
  import dip_pkg::*;
#(
  parameter int WIDTH        = DIP_WIDTH,
  parameter int STABLE_SCANS = DIP_STABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] cur,
  output logic             commit
);

  logic [WIDTH-1:0] prev;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;

  // Match count after this scan; saturates once the word is stable.
  always_comb begin
    cnt_nxt = cnt;
    if (word == prev) begin
      if (cnt != 4'(STABLE_SCANS))
        cnt_nxt = cnt + 4'd1;
    end else begin
      cnt_nxt = 4'd1;
    end
  end

  assign commit = word_valid
               && (cnt_nxt == 4'(STABLE_SCANS))
               && (word != cur);

  // Remember the last scan word and its run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      cnt  <= '0;
    end else if (word_valid) begin
      prev <= word;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dip_reader.sv
// dip_reader: scans an external 74HC165-style DIP chain into a word.
// Define DIP_DEBOUNCE_EN to require STABLE_SCANS equal scans per update.
module dip_reader
  import dip_pkg::*;
#(
  parameter int WIDTH      = DIP_WIDTH,
  parameter int GAP        = DIP_GAP,
`ifdef DIP_DEBOUNCE_EN
  parameter int STABLE_SCANS = DIP_STABLE,
`endif
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             DIP_data,
  output logic             DIP_latch,
  output logic [WIDTH-1:0] DIP_out,
  output logic             DIP_valid,
  output logic             DIP_changed
);

  localparam int   CW     = $clog2(WIDTH + 1);
  localparam logic AL_BIT = (ACTIVE_LOW != 0);

  dip_state_t       state;
  logic [7:0]       gap_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_nxt;
  logic             bit_in;
  logic             last_bit;
  logic             gap_at;
  logic             upd;

  assign bit_in   = DIP_data ^ AL_BIT;
  assign sh_nxt   = WIDTH'({shreg, bit_in});
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign gap_at   = (gap_cnt == 8'(GAP));

`ifdef DIP_DEBOUNCE_EN
  dip_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_SCANS (STABLE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (state == SHIFT && last_bit),
    .word       (sh_nxt),
    .cur        (DIP_out),
    .commit     (upd)
  );
`else
  assign upd = 1'b1;
`endif

  // Scan sequencer: gap wait, load pulse, serial shift, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      DIP_latch   <= 1'b1;
      DIP_out     <= '0;
      DIP_valid   <= 1'b0;
      DIP_changed <= 1'b0;
    end else begin
      DIP_valid   <= 1'b0;
      DIP_changed <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (!gap_at) begin
            gap_cnt <= gap_cnt + 8'd1;
          end else if (scan_en) begin
            state     <= LOAD;
            DIP_latch <= 1'b0;
          end
        end
        LOAD: begin
          state     <= SHIFT;
          DIP_latch <= 1'b1;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          shreg <= sh_nxt;
          if (last_bit) begin
            state     <= DONE;
            gap_cnt   <= '0;
            DIP_valid <= 1'b1;
            if (upd) begin
              DIP_out     <= sh_nxt;
              DIP_changed <= (sh_nxt != DIP_out);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dip_reader.sv
// tb_dip_reader: scoreboard bench for dip_reader with a 74HC165 chain model.
// Expected words are queued at each load pulse and checked at DIP_valid.
module tb_dip_reader;
  import dip_pkg::*;

  localparam int W  = 8;
  localparam int G  = 4;
  localparam int AL = 1;
  localparam int SS = 3;
  localparam int W2 = 16;
  localparam int G2 = 0;
  localparam logic [W-1:0] ALM = (AL != 0) ? '1 : '0;
`ifdef DIP_DEBOUNCE_EN
  localparam int DEB = 1;
`else
  localparam int DEB = 0;
`endif
  localparam int EXP_CHG = DEB ? 1 : 2;
  localparam logic [W-1:0] EXP_S3 = DEB ? 8'h00 : 8'h22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_en = 1'b0;

  logic         dip_data, dip_latch, dip_valid, dip_changed;
  logic [W-1:0] dip_out;
  logic         d16_data, d16_latch, d16_valid, d16_changed;
  logic [W2-1:0] d16_out;

  always #5 clk = ~clk;

  dip_reader #(.WIDTH(W), .GAP(G), .ACTIVE_LOW(AL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .DIP_data    (dip_data),
    .DIP_latch   (dip_latch),
    .DIP_out     (dip_out),
    .DIP_valid   (dip_valid),
    .DIP_changed (dip_changed)
  );

  dip_reader #(.WIDTH(W2), .GAP(G2), .ACTIVE_LOW(0)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .DIP_data    (d16_data),
    .DIP_latch   (d16_latch),
    .DIP_out     (d16_out),
    .DIP_valid   (d16_valid),
    .DIP_changed (d16_changed)
  );

  // External PISO chains: load while latch low, else shift MSB out.
  logic [W-1:0]  pattern = '0;
  logic [W-1:0]  chain = '0;
  logic [W2-1:0] chain16 = '0;
  always @(posedge clk) begin
    if (!dip_latch) chain <= pattern;
    else chain <= chain << 1;
    if (!d16_latch) chain16 <= 16'h8001;
    else chain16 <= chain16 << 1;
  end
  assign dip_data = chain[W-1];
  assign d16_data = chain16[W2-1];

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  logic [W-1:0] sb_q[$];
  logic [W-1:0] m_out, m_prev, raw, word;
  int  m_cnt;
  logic e_chg;
  int  load_cyc, first_load, first_valid;
  bit  have_prev, en_drop, prev_latch;

  // Scoreboard monitor for the 8-bit reader.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      have_prev = 0;
      en_drop = 0;
      first_load = -1;
      first_valid = -1;
      m_out = '0;
      m_prev = '0;
      m_cnt = 0;
      prev_latch = 1;
    end else begin
      if (!scan_en) en_drop = 1;
      if (!dip_latch) begin
        chk("latch_width", 32'(prev_latch), 32'd1);
        if (have_prev && !en_drop)
          chk("period", cyc - load_cyc, G + W + 2);
        if (first_load < 0) first_load = cyc;
        load_cyc = cyc;
        have_prev = 1;
        en_drop = 0;
        sb_q.push_back(pattern);
      end
      if (dip_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (sb_q.size() == 0) begin
          chk("spurious_valid", 32'(dip_valid), 32'd0);
        end else begin
          raw = sb_q.pop_front();
          word = raw ^ ALM;
          if (DEB != 0) begin
            if (word == m_prev) m_cnt++;
            else m_cnt = 1;
            m_prev = word;
            e_chg = (m_cnt >= SS) && (word != m_out);
          end else begin
            e_chg = (word != m_out);
          end
          if (e_chg) m_out = word;
          chk("latency", cyc - load_cyc, W + 1);
          chk("dip_out", 32'(dip_out), 32'(m_out));
          chk("changed", 32'(dip_changed), 32'(e_chg));
        end
      end else if (dip_changed) begin
        chk("changed_alone", 32'(dip_changed), 32'd0);
      end
      prev_latch = dip_latch;
    end
  end

  int v16_first, v16_prev, v16_last;
  // Timing record for the 16-bit, zero-gap reader.
  always @(negedge clk) begin
    if (!rst_n) begin
      v16_first = -1;
      v16_prev = 0;
      v16_last = 0;
    end else if (d16_valid) begin
      if (v16_first < 0) v16_first = cyc;
      v16_prev = v16_last;
      v16_last = cyc;
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!dip_valid && n < 200);
    if (!dip_valid) chk(tag, 32'(dip_valid), 32'd1);
  endtask

  task automatic wait_load(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (dip_latch && n < 200);
    if (dip_latch) chk(tag, 32'(dip_latch), 32'd0);
  endtask

  logic [W-1:0] seq [4] = '{8'h11, 8'h22, 8'h22, 8'h22};

  initial begin
    int n_lat, n_val, n, n_chg;
    pattern = ~8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(dip_latch), 32'd1);
    chk("rst_out", 32'(dip_out), 32'd0);
    chk("rst_valid", 32'(dip_valid), 32'd0);
    chk("rst_changed", 32'(dip_changed), 32'd0);
    #1;
    scan_en = 1'b1;
    rst_n = 1'b1;

    wait_valid("tmo_v1");
    @(negedge clk); #1;
    chk("first_load", first_load, G + 1);
    chk("first_valid", first_valid, 14);
    wait_valid("tmo_v2");
    pattern = ~8'hF0;
    wait_valid("tmo_v3");
    wait_valid("tmo_v4");
    wait_valid("tmo_v5");
    chk("w16_first", v16_first, 18);
    chk("w16_period", v16_last - v16_prev, W2 + G2 + 2);
    chk("w16_out", 32'(d16_out), 32'h8001);

    wait_load("tmo_l_drop");
    repeat (4) @(posedge clk);
    #1;
    scan_en = 1'b0;
    wait_valid("tmo_v_drop");
    n_lat = 0;
    n_val = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!dip_latch) n_lat++;
      if (dip_valid) n_val++;
    end
    chk("idle_latch", n_lat, 0);
    chk("idle_valid", n_val, 0);
    scan_en = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (dip_latch && n < 50);
    chk("relaunch", n, 1);

    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_latch", 32'(dip_latch), 32'd1);
    chk("abort_out", 32'(dip_out), 32'd0);
    pattern = ~8'h3C;
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_valid("tmo_fresh");
    @(negedge clk); #1;
    chk("fresh_load", first_load, G + 1);

    rst_n = 1'b0;
    pattern = ~seq[0];
    @(negedge clk); #1;
    rst_n = 1'b1;
    n_chg = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid("tmo_db");
      if (dip_changed) n_chg++;
      if (i == 2) chk("db_scan3", 32'(dip_out), 32'(EXP_S3));
      if (i < 3) pattern = ~seq[i+1];
    end
    chk("db_final", 32'(dip_out), 32'h22);
    chk("db_changes", n_chg, EXP_CHG);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
